io_bus_arbiter: RTL
===================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra I/O access cycles per transaction (range 0..7).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req / m1_req  input  1  transaction request, master 0 (CPU) / master 1 (debug loader).
REQ-005 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr / m1_addr  input  4  I/O port address.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  8  write data.
REQ-008 SHALL have ports m0_gnt / m1_gnt  output  1  master owns bus, ACCESS and DONE states.
REQ-009 SHALL have ports m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  8  read data captured for the last completed read.
REQ-011 SHALL have ports io_addr  output  4; io_wdata  output  8; io_rdata  input  8; io_oe  output  1  read strobe; io_we  output  1  write strobe.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
- IDLE -> ACCESS when any req = 1.
- ACCESS -> DONE after WAIT_CYCLES+1 cycles.
- DONE -> IDLE unconditionally.
REQ-013 SHALL, on the IDLE -> ACCESS edge, latch the winner's we/addr/wdata; io_addr and io_wdata SHALL stay constant for all ACCESS cycles.
REQ-014 SHALL arbitrate round-robin: with both req = 1, the master not granted last wins; with one req, that master wins.
REQ-015 SHALL assert the winner's gnt for every ACCESS and DONE cycle; at most one gnt = 1 at any time.
REQ-016 SHALL, for reads, assert io_oe for all ACCESS cycles and load rdata from io_rdata on the final ACCESS cycle.
REQ-017 SHALL, for writes, assert io_we for exactly one cycle (the final ACCESS cycle), with io_oe = 0 throughout.
REQ-018 SHALL pulse the owner's done for exactly the DONE cycle, with io_oe = io_we = 0 in DONE.
REQ-019 SHALL, in IDLE, drive io_oe = io_we = 0, io_addr = 0 and io_wdata = 0.
REQ-020 SHALL, for a req seen in IDLE at cycle t, assert gnt from t+1 and done at t+2+WAIT_CYCLES. A transaction takes 3+WAIT_CYCLES cycles from the req edge back to IDLE.
REQ-021 SHALL ignore req deassertion during ACCESS/DONE; the latched transaction completes normally.
REQ-022 SHALL re-arbitrate only in IDLE; a master holding req after done gets a new transaction only if it wins arbitration again.
REQ-023 SHALL use a wait counter 3 bits wide; it reloads on entry to ACCESS and never wraps mid-transaction.

Reset
REQ-024 SHALL, when reset = 1 at a rising edge, go to IDLE regardless of state, aborting any transaction without a done pulse.
REQ-025 SHALL, on reset, clear all outputs (gnt, done, io_oe, io_we, io_addr, io_wdata, rdata) to 0 and the wait counter to 0.
REQ-026 SHALL, on reset, set last-grant to master 1, so master 0 wins the first tie.

Structure
REQ-027 SHALL take state encoding, IO_ADDR_W = 4, IO_DATA_W = 8 and NUM_MASTERS = 2 from shared package io_arb_pkg.
REQ-028 SHALL place round-robin selection in sub-module io_rr_picker: combinational winner from req plus last-grant.

Verification
REQ-029 Single read: WAIT_CYCLES=1, m0 reads addr 0x3, io_rdata=0xA5 -> io_oe high 2 cycles, m0_done at t+3, rdata=0xA5.
REQ-030 Single write: m1 writes 0x5C to addr 0xF -> io_we high exactly 1 cycle with io_addr=0xF and io_wdata=0x5C; m1_done once.
REQ-031 Contention: both req held continuously from reset -> grants alternate m0, m1, m0, m1; gnts never overlap.
REQ-032 Reset mid-ACCESS: reset asserted on 2nd ACCESS cycle -> next cycle IDLE, all outputs 0, no done; next tie goes to m0.
REQ-033 Zero wait: WAIT_CYCLES=0, m0 write -> io_we on cycle t+1, done at t+2, back in IDLE at t+3.
REQ-034 Req drop: m0_req falls one cycle after grant -> transaction still completes, done pulses, rdata updated.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared definitions for the two-master I/O bus arbiter.
// Bus widths, master count and FSM state encoding.
package io_arb_pkg;

    localparam int IO_ADDR_W   = 4;
    localparam int IO_DATA_W   = 8;
    localparam int NUM_MASTERS = 2;
    localparam int WAIT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/io_rr_picker.sv
// Round-robin winner select for two masters.
// Purely combinational; the caller holds the last-grant state.
module io_rr_picker
    import io_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   last_i,
    output logic                   any_o,
    output logic                   win_o
);

    always_comb begin
        any_o = |req_i;
        win_o = 1'b0;
        unique case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = ~last_i;
            default: win_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter in front of a single I/O port bus.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES+1) -> DONE.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m1_req,
    input  logic                 m0_we,
    input  logic                 m1_we,
    input  logic [IO_ADDR_W-1:0] m0_addr,
    input  logic [IO_ADDR_W-1:0] m1_addr,
    input  logic [IO_DATA_W-1:0] m0_wdata,
    input  logic [IO_DATA_W-1:0] m1_wdata,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic                 m0_done,
    output logic                 m1_done,
    output logic [IO_DATA_W-1:0] rdata,
    output logic [IO_ADDR_W-1:0] io_addr,
    output logic [IO_DATA_W-1:0] io_wdata,
    input  logic [IO_DATA_W-1:0] io_rdata,
    output logic                 io_oe,
    output logic                 io_we
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    arb_state_e           state_q, state_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic [IO_ADDR_W-1:0] addr_q, addr_d;
    logic [IO_DATA_W-1:0] wdata_q, wdata_d;
    logic [IO_DATA_W-1:0] rdata_q, rdata_d;
    logic                 any_req;
    logic                 win;
    logic                 last_acc;

    io_rr_picker u_pick (
        .req_i  ({m1_req, m0_req}),
        .last_i (owner_q),
        .any_o  (any_req),
        .win_o  (win)
    );

    assign last_acc = (state_q == ST_ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_LD;
                    owner_d = win;
                    we_d    = win ? m1_we    : m0_we;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!we_q) rdata_d = io_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // owner_q doubles as last-grant; reset to master 1 so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        m0_gnt   = (state_q != ST_IDLE) && !owner_q;
        m1_gnt   = (state_q != ST_IDLE) &&  owner_q;
        m0_done  = (state_q == ST_DONE) && !owner_q;
        m1_done  = (state_q == ST_DONE) &&  owner_q;
        io_oe    = (state_q == ST_ACCESS) && !we_q;
        io_we    = last_acc && we_q;
        io_addr  = (state_q == ST_ACCESS) ? addr_q  : '0;
        io_wdata = (state_q == ST_ACCESS) ? wdata_q : '0;
        rdata    = rdata_q;
    end

endmodule
